// File: rtl/ascon_pack.sv
// Shared types and constants for the Ascon permutation: state layout, FSM
// encoding, round counts and the round-constant table.
package ascon_pack;

  // 320-bit state; word [4] is S_0 (most significant), word [0] is S_4.
  typedef logic [4:0][63:0] type_state;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam int unsigned NB_ROUNDS_P12   = 12;
  localparam int unsigned NB_ROUNDS_P6    = 6;
  localparam logic [3:0]  LAST_ROUND      = 4'(NB_ROUNDS_P12 - 1);
  localparam logic [3:0]  FIRST_ROUND_P12 = 4'd0;
  localparam logic [3:0]  FIRST_ROUND_P6  = 4'(NB_ROUNDS_P12 - NB_ROUNDS_P6);

  // Entry r holds 0xF0 - r*0x0F; entry 0 is the least significant byte.
  localparam logic [11:0][7:0] ROUND_CONST = {
    8'h4b, 8'h5a, 8'h69, 8'h78, 8'h87, 8'h96,
    8'ha5, 8'hb4, 8'hc3, 8'hd2, 8'he1, 8'hf0
  };

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/addition_constante.sv
// Constant-addition layer p_c: XORs the round constant into the low byte of S_2.
// Purely combinational.
module addition_constante
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [3:0] round_i,
  output type_state  state_o
);

  always_comb begin
    state_o = state_i;
    if (round_i <= LAST_ROUND) begin
      state_o[2][7:0] = state_i[2][7:0] ^ ROUND_CONST[round_i];
    end
  end

endmodule

// File: rtl/ascon_round.sv
// One full Ascon round: p_c, then bit-sliced 5-bit S-box p_s, then linear
// diffusion p_l. Purely combinational.
module ascon_round
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [3:0] round_i,
  output type_state  state_o
);

  type_state   pc_state;
  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;

  addition_constante u_pc (
    .state_i (state_i),
    .round_i (round_i),
    .state_o (pc_state)
  );

  always_comb begin
    x0 = pc_state[4];
    x1 = pc_state[3];
    x2 = pc_state[2];
    x3 = pc_state[1];
    x4 = pc_state[0];

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    state_o[4] = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
    state_o[3] = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
    state_o[2] = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
    state_o[1] = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
    state_o[0] = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
  end

endmodule

// File: rtl/permutation_seq.sv
// Iterative Ascon permutation, one round per clock: p^12 or p^6.
// done_o rises 12 (p^12) or 6 (p^6) edges after start; start_i is ignored while busy.
module permutation_seq
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       mode_i,
  input  type_state  state_i,
  output type_state  state_o,
  output logic [3:0] round_o,
  output logic       busy_o,
  output logic       done_o
);

  fsm_t       fsm_q, fsm_d;
  type_state  state_q, state_d;
  logic [3:0] round_q, round_d;
  type_state  round_out;

  ascon_round u_round (
    .state_i (state_q),
    .round_i (round_q),
    .state_o (round_out)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    case (fsm_q)
      IDLE, DONE: begin
        if (start_i) begin
          fsm_d   = RUN;
          state_d = state_i;
          round_d = mode_i ? FIRST_ROUND_P6 : FIRST_ROUND_P12;
        end else if (fsm_q == DONE) begin
          fsm_d = IDLE;
        end
      end
      RUN: begin
        state_d = round_out;
        // The last round parks the counter at 11 rather than wrapping.
        if (round_q == LAST_ROUND) begin
          fsm_d = DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign state_o = state_q;
  assign round_o = round_q;
  assign busy_o  = (fsm_q == RUN);
  assign done_o  = (fsm_q == DONE);

endmodule
